light_level_ctrl: RTL

Parametrised multi-level light controller: converts three push-button inputs (up, down, off) into a brightness level with NUM_LEVELS steps. The level drives a registered PWM output. An optional inactivity timer returns the light to off. It sits between the debounced button inputs and the lamp driver, and is the generalised, edge-triggered successor of the fixed five-level light-stand FSM.

---
 rtl/light_level_ctrl_if.sv | 24 ++
 rtl/light_level_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/light_level_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : light_level_ctrl_if
//  Description : Button/lamp signal bundle for light_level_ctrl.
//                master : button source / lamp-driver side (drives i_button)
//                slave  : the controller (drives o_level, o_on, o_pwm)
//  Signals     : i_button [2:0]  [0]=up, [1]=down, [2]=off
//                o_level  [LEVEL_W-1:0] current brightness level
//                o_on     high when o_level != 0
//                o_pwm    registered PWM lamp drive
//  Revision    : 1.0  initial release
// ============================================================================
interface light_level_ctrl_if #(
    parameter int LEVEL_W = 3
);
    logic [2:0]         i_button;
    logic [LEVEL_W-1:0] o_level;
    logic               o_on;
    logic               o_pwm;

    modport master (output i_button, input o_level, input o_on, input o_pwm);
    modport slave  (input i_button, output o_level, output o_on, output o_pwm);
endinterface
`default_nettype wire

// File: rtl/light_level_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : light_level_ctrl
//  Description : Multi-level light controller. Rising edges on the up/down/off
//                buttons step a brightness level (priority up > down > off),
//                and the level drives a registered PWM output whose period is
//                (NUM_LEVELS-1)*PWM_STEP cycles.
//                Optional feature macro: LIGHT_AUTO_OFF_EN -- when defined, an
//                inactivity counter returns the light to level 0 after
//                AUTO_OFF_CYCLES cycles without a press.
//  Ports       : i_clk      system clock, rising edge
//                i_reset_n  asynchronous active-low reset
//                bus        light_level_ctrl_if.slave
//                           (i_button in, o_level/o_on/o_pwm out)
//  Revision    : 1.0  initial release
// ============================================================================
module light_level_ctrl #(
    parameter int NUM_LEVELS      = 5,
    parameter int LEVEL_W         = 3,
    parameter int PWM_STEP        = 4,
    parameter int AUTO_OFF_CYCLES = 1000000
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset_n,
    light_level_ctrl_if.slave      bus
);

    // Compare width holds the full period value so level*PWM_STEP at the top
    // level (which equals the period) never overflows.
    localparam int                 c_period    = (NUM_LEVELS - 1) * PWM_STEP;
    localparam int                 c_cmp_w     = $clog2(c_period + 1);
    localparam logic [LEVEL_W-1:0] c_max_level = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [c_cmp_w-1:0] c_cnt_last  = c_cmp_w'(c_period - 1);
    localparam logic [c_cmp_w-1:0] c_step      = c_cmp_w'(PWM_STEP);

    logic [2:0]         r_btn_q;
    logic [2:0]         w_press;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic [c_cmp_w-1:0] r_pwm_cnt;
    logic [c_cmp_w-1:0] w_duty;
    logic               r_pwm;
    logic               w_expire;

    assign w_press = bus.i_button & ~r_btn_q;

`ifdef LIGHT_AUTO_OFF_EN
    localparam int                  c_ao_w    = $clog2(AUTO_OFF_CYCLES);
    localparam logic [c_ao_w-1:0]   c_ao_last = c_ao_w'(AUTO_OFF_CYCLES - 1);

    logic [c_ao_w-1:0] r_ao_cnt;

    // The counter is held at zero while the light is off, so reaching the
    // terminal value implies a non-zero level.
    assign w_expire = (r_ao_cnt == c_ao_last);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ao_cnt <= '0;
        end else if ((|w_press) || (r_level == '0) || w_expire) begin
            r_ao_cnt <= '0;
        end else begin
            r_ao_cnt <= r_ao_cnt + 1'b1;
        end
    end
`else
    localparam int c_unused_auto_off = AUTO_OFF_CYCLES;
    assign w_expire = 1'b0;
`endif

    // Level state register and edge-detect register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level <= '0;
            r_btn_q <= 3'b000;
        end else begin
            r_level <= w_level_nxt;
            r_btn_q <= bus.i_button;
        end
    end

    // Next level: only the highest-priority press acts; the rest are dropped.
    // Any press takes precedence over the timeout.
    always_comb begin
        w_level_nxt = r_level;
        if (w_press[0]) begin
            if (r_level != c_max_level) begin
                w_level_nxt = r_level + 1'b1;
            end
        end else if (w_press[1]) begin
            if (r_level != '0) begin
                w_level_nxt = r_level - 1'b1;
            end
        end else if (w_press[2]) begin
            w_level_nxt = '0;
        end else if (w_expire) begin
            w_level_nxt = '0;
        end
    end

    // r_level <= NUM_LEVELS-1 <= c_period, so narrowing to c_cmp_w is lossless.
    assign w_duty = c_cmp_w'(r_level) * c_step;

    // Free-running PWM phase; a level change never restarts it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_cnt_last) ? '0 : r_pwm_cnt + 1'b1;
            r_pwm     <= (r_pwm_cnt < w_duty);
        end
    end

    assign bus.o_level = r_level;
    assign bus.o_on    = |r_level;
    assign bus.o_pwm   = r_pwm;

endmodule
`default_nettype wire
